if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF pipeline register and feeds it PC and Instruction. Owns the fetch PC, issues pipelined requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned words in a small prefetch FIFO. Handles branch redirection (flushes the FIFO, drops in-flight responses) and freeze from the hazard unit.

Parameters:
FIFO_DEPTH, 4, prefetch entries; power of two, >=2; also caps in-flight requests.
RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-low reset: sampled on posedge clk, rst==0 resets all state
freeze  in  1  hazard stall; head instruction held, not consumed
branch_taken  in  1  redirect request from EXE
branch_addr  in  32  redirect target, word aligned
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (= fetch_pc)
imem_gnt  in  1  request accepted this cycle when imem_req&imem_gnt
imem_rvalid  in  1  response valid; responses in request order, >=1 cycle after grant
imem_rdata  in  32  response word
valid_out  out  1  FIFO head valid
pc_out  out  32  head instruction address + 4
instruction_out  out  32  head instruction word; 32'h0 when valid_out==0

Behaviour:
- Reset (rst==0 at posedge): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard_cnt=0. Outputs then: imem_req=0 during any cycle rst==0; valid_out=0, pc_out=0, instruction_out=0.
- Issue: imem_req = rst & (outstanding + fifo_count < FIFO_DEPTH). imem_addr=fetch_pc. On grant, fetch_pc+=4 (32-bit wrap, 32'hFFFF_FFFC -> 0), outstanding+=1.
- imem_addr stable while imem_req&~imem_gnt, except across a redirect.
- Response: imem_rvalid with discard_cnt==0 pushes {addr+4, rdata}; address tracked per entry (resp_pc counter loaded with fetch_pc at redirect/reset). outstanding-=1. With discard_cnt>0: word dropped, discard_cnt-=1.
- Push never overflows (credit rule guarantees space); rvalid with outstanding==0 is a protocol error (assertion).
- Consume: pop when valid_out & ~freeze. Outputs are combinational from head. Push and pop same cycle on full or empty FIFO both legal; count unchanged on simultaneous push+pop.
- Empty FIFO: valid_out=0, instruction_out=0 (NOP bubble), pc_out=0.
- Redirect (branch_taken==1, priority over freeze): valid_out forced 0 that cycle; next cycle FIFO empty, fetch_pc=resp_pc=branch_addr, discard_cnt = outstanding (after this cycle's grant/response accounting: a grant in the branch cycle is counted, an rvalid in the branch cycle is dropped), outstanding unchanged. New requests may issue from the following cycle even while discard_cnt>0.
- States: RUN (discard_cnt==0), DRAIN (discard_cnt>0); DRAIN->RUN when last stale response dropped. Second redirect during DRAIN: discard_cnt = total outstanding again.
- Reset mid-operation: all counters cleared; responses for pre-reset requests are the memory's responsibility (memory reset with same rst).
- Latency: grant at cycle N, rvalid at N+k -> valid_out at N+k+1.

Decomposition:
- Shared package: NOP_INSTR=32'h0, INSTR_BYTES=4, PC_WIDTH=32, ADDR_ALIGN_MASK.
- One sub-module: fetch_fifo (synchronous FIFO, DEPTH param, 64-bit entries {pc,instr}, push/pop/full/empty/count, synchronous active-low reset).

Test Plan:
- Reset release, gnt=1 always, rvalid 1 cycle after grant, mem[a]=a^32'hA5A5_0000 -> valid_out from cycle 3, pc_out 4,8,12,... with matching instruction_out, one per cycle.
- freeze=1 for 10 cycles -> FIFO fills to 4, imem_req=0 once outstanding+count==4, head stays pc_out=4; release -> 4,8,12,16,20 in order, none lost.
- imem_gnt low 5 cycles -> imem_req held, imem_addr constant; valid_out drops to 0 with instruction_out=0.
- 3-cycle memory latency, branch_taken to 32'h100 with 2 outstanding -> 2 responses dropped, next valid_out has pc_out=32'h104, instruction=mem[32'h100].
- branch_taken coincident with imem_gnt and imem_rvalid -> both stale words dropped; no stale pc_out ever appears.
- rst=0 for one cycle mid-stream with FIFO full -> next cycle valid_out=0, imem_req=0; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants and types for the instruction fetch unit
package if_fetch_unit_pkg;

    localparam int PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] INSTR_BYTES     = 32'd4;
    localparam logic [PC_WIDTH-1:0] NOP_INSTR       = 32'h0000_0000;
    localparam logic [PC_WIDTH-1:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [PC_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// rtl/if_fetch_unit_fifo.sv - prefetch FIFO holding {pc, instr} entries
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch PC owner, pipelined imem requester and prefetch buffer
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = CW + 1;

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] fifo_count;
    logic [IW-1:0] in_use;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          grant;
    logic          accept;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;

    // Every slot is either buffered or in flight, so a push can never overflow
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req  = rst & (in_use < IW'(FIFO_DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;
    assign accept    = imem_rvalid & (state == RUN) & ~branch_taken;

    assign valid_out       = rst & ~fifo_empty & ~branch_taken;
    assign pop             = valid_out & ~freeze;
    assign pc_out          = valid_out ? head.pc : '0;
    assign instruction_out = valid_out ? head.instr : NOP_INSTR;
    assign push_entry      = '{pc: resp_pc + INSTR_BYTES, instr: imem_rdata};

    always_comb begin
        outstanding_next = outstanding;
        case ({grant, imem_rvalid})
            2'b10:   outstanding_next = outstanding + 1'b1;
            2'b01:   outstanding_next = outstanding - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (branch_taken) begin
                // Everything still in flight after this cycle belongs to the old path
                fetch_pc    <= branch_addr & ADDR_ALIGN_MASK;
                resp_pc     <= branch_addr & ADDR_ALIGN_MASK;
                discard_cnt <= outstanding_next;
                state       <= (outstanding_next != '0) ? DRAIN : RUN;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + INSTR_BYTES;
                end
                if (accept) begin
                    resp_pc <= resp_pc + INSTR_BYTES;
                end
                if (imem_rvalid && state == DRAIN) begin
                    discard_cnt <= discard_cnt - 1'b1;
                    if (discard_cnt == CW'(1)) begin
                        state <= RUN;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && imem_rvalid) begin
            assert (outstanding != '0);
        end
        if (rst && accept) begin
            assert (!fifo_full || pop);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (branch_taken),
        .push  (accept),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit against a transaction-level model
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;

    if_fetch_unit #(
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .valid_out       (valid_out),
        .pc_out          (pc_out),
        .instruction_out (instruction_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } req_t;

    req_t        inflight[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_ins_q[$];
    logic [31:0] m_fetch_pc = 32'h0;
    int          lat = 1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model
    task automatic cycle(input logic r, input logic f, input logic b,
                         input logic [31:0] ba, input logic g);
        logic        rv;
        logic        e_req;
        logic        e_val;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        req_t        x;
        @(negedge clk);
        rst          = r;
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        imem_gnt     = g;
        rv = r && inflight.size() > 0 && inflight[0].due <= cyc;
        imem_rvalid  = rv;
        imem_rdata   = rv ? mem_word(inflight[0].addr) : 32'hDEAD_BEEF;
        #1;
        e_req = r && (inflight.size() + exp_pc_q.size() < 4);
        e_val = r && !b && exp_pc_q.size() > 0;
        e_pc  = e_val ? exp_pc_q[0] : 32'h0;
        e_ins = e_val ? exp_ins_q[0] : 32'h0;
        check("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) check("imem_addr", imem_addr, m_fetch_pc);
        check("valid_out", 32'(valid_out), 32'(e_val));
        check("pc_out", pc_out, e_pc);
        check("instruction_out", instruction_out, e_ins);
        if (!r) begin
            inflight.delete();
            exp_pc_q.delete();
            exp_ins_q.delete();
            m_fetch_pc = 32'h0;
        end else begin
            if (e_val && !f) begin
                void'(exp_pc_q.pop_front());
                void'(exp_ins_q.pop_front());
            end
            if (rv) begin
                x = inflight.pop_front();
                if (!x.stale && !b) begin
                    exp_pc_q.push_back(x.addr + 32'd4);
                    exp_ins_q.push_back(mem_word(x.addr));
                end
            end
            if (e_req && g) begin
                inflight.push_back('{m_fetch_pc, 1'b0, cyc + lat});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (b) begin
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                exp_pc_q.delete();
                exp_ins_q.delete();
                m_fetch_pc = ba;
            end
        end
        cyc++;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc, input logic [31:0] ins);
        int n = 0;
        while (!valid_out && n < 20) begin
            cycle(1, 0, 0, 32'h0, 1);
            n++;
        end
        check({name, "_valid"}, 32'(valid_out), 32'd1);
        check({name, "_pc"}, pc_out, pc);
        check({name, "_instr"}, instruction_out, ins);
    endtask

    initial begin
        repeat (2) cycle(0, 0, 0, 32'h0, 0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);

        // Streaming with single-cycle memory
        lat = 1;
        cycle(1, 0, 0, 32'h0, 1);
        check("p1_first_addr", imem_addr, 32'h0);
        cycle(1, 0, 0, 32'h0, 1);
        check("p1_not_yet", 32'(valid_out), 32'd0);
        cycle(1, 0, 0, 32'h0, 1);
        check("p1_pc0", pc_out, 32'd4);
        check("p1_ins0", instruction_out, 32'hA5A5_0000);
        cycle(1, 0, 0, 32'h0, 1);
        check("p1_pc1", pc_out, 32'd8);
        check("p1_ins1", instruction_out, 32'hA5A5_0004);
        repeat (6) cycle(1, 0, 0, 32'h0, 1);

        // Freeze fills the FIFO, release drains it in order
        cycle(0, 0, 0, 32'h0, 0);
        repeat (10) cycle(1, 1, 0, 32'h0, 1);
        check("p2_req_blocked", 32'(imem_req), 32'd0);
        check("p2_head_pc", pc_out, 32'd4);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 32'h0, 1);
            check("p2_order", pc_out, 32'(4 * (i + 1)));
        end

        // Grant withheld: request held, FIFO runs dry
        repeat (3) cycle(1, 0, 0, 32'h0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 32'h0, 0);
            check("p3_req_held", 32'(imem_req), 32'd1);
        end
        check("p3_valid_drop", 32'(valid_out), 32'd0);
        check("p3_nop", instruction_out, 32'h0);
        repeat (4) cycle(1, 0, 0, 32'h0, 1);

        // Redirect with two requests in flight at 3-cycle latency
        cycle(0, 0, 0, 32'h0, 0);
        lat = 3;
        cycle(1, 0, 0, 32'h0, 1);
        cycle(1, 0, 0, 32'h0, 1);
        cycle(1, 0, 1, 32'h100, 0);
        wait_valid("p4", 32'h104, 32'hA5A5_0100);
        repeat (6) cycle(1, 0, 0, 32'h0, 1);

        // Redirect coincident with grant and response
        cycle(0, 0, 0, 32'h0, 0);
        lat = 2;
        repeat (6) cycle(1, 0, 0, 32'h0, 1);
        cycle(1, 0, 1, 32'h200, 1);
        wait_valid("p5", 32'h204, 32'hA5A5_0200);
        repeat (6) cycle(1, 0, 0, 32'h0, 1);

        // Address wrap at the top of the space
        cycle(0, 0, 0, 32'h0, 0);
        lat = 1;
        cycle(1, 0, 1, 32'hFFFF_FFF8, 1);
        wait_valid("p6", 32'hFFFF_FFFC, 32'h5A5A_FFF8);
        cycle(1, 0, 0, 32'h0, 1);
        check("p6_wrap_pc", pc_out, 32'h0);
        check("p6_wrap_ins", instruction_out, 32'h5A5A_FFFC);
        repeat (4) cycle(1, 0, 0, 32'h0, 1);

        // Reset mid-stream with a full FIFO
        repeat (10) cycle(1, 1, 0, 32'h0, 1);
        cycle(0, 1, 0, 32'h0, 1);
        check("p7_rst_req", 32'(imem_req), 32'd0);
        cycle(1, 0, 0, 32'h0, 1);
        check("p7_valid", 32'(valid_out), 32'd0);
        check("p7_addr", imem_addr, 32'h0);
        wait_valid("p7", 32'd4, 32'hA5A5_0000);
        repeat (4) cycle(1, 0, 0, 32'h0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
